cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run-control sequencer directly upstream of the CPU status block. It turns decoded monitor commands (start, quit, single/multi-step, breakpoint set/clear) into the `cpu_start` / `quit_cmd` pulses and start address that the status block consumes. It also waits for DRAM calibration, watches the retiring PC for a breakpoint match, and stops the core after a programmed number of instructions.

## Interface
Parameters:
- HALT_CYC, 5: cycles held in HALTING after a quit pulse; covers pipeline reset drain.
- STEP_W, 16: width of step count.
- RESET_ADR, 32'h0000_0000: reset value of `start_adr`.

Ports:
- clk  in  1  core clock; the block's only clock.
- rst_n  in  1  reset. **Synchronous, active-high**: the block resets on a rising `clk` edge while `rst_n`=1.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`.
- cmd_code  in  3  1=START, 2=QUIT, 3=STEP, 4=BRK_SET, 5=BRK_CLR; others are accepted and ignored.
- cmd_data  in  32  START: start address; STEP: count[STEP_W-1:0]; BRK_SET: breakpoint PC.
- init_calib_complete  in  1  DRAM calibration done.
- pc_valid  in  1  one instruction retired this cycle; already qualified by `~stall`.
- pc_ret  in  32  PC of the retired instruction.
- cpu_start  out  1  one-cycle start pulse.
- quit_cmd  out  1  one-cycle quit pulse.
- start_adr  out  32  address used by the PC stage on `pc_start`.
- running  out  1  high in RUN and STEP.
- brk_hit  out  1  sticky; set on breakpoint stop, cleared by the next accepted START or STEP.
- step_done  out  1  one-cycle pulse when a step sequence ends.

## Operation
States: IDLE, WAIT_CAL, RUN, STEP, HALTING.
- **IDLE, START**:
  - Latch `start_adr` = `cmd_data`.
  - If `init_calib_complete`=1: go to RUN and pulse `cpu_start`.
  - Otherwise go to WAIT_CAL.
- **IDLE, STEP**:
  - Load the step counter with `cmd_data[STEP_W-1:0]`; a count of 0 is treated as 1.
  - `start_adr` is unchanged.
  - If calibrated: go to STEP and pulse `cpu_start`. Otherwise go to WAIT_CAL, remembering the STEP target.
- **WAIT_CAL**:
  - When `init_calib_complete` rises, pulse `cpu_start` and go to the remembered RUN or STEP.
  - QUIT returns to IDLE with no `quit_cmd` pulse.
- **RUN**: QUIT pulses `quit_cmd` and goes to HALTING.
- **STEP**: each `pc_valid` decrements the counter. When the counter reaches 0:
  - pulse `quit_cmd` and `step_done`;
  - go to HALTING.
- **Breakpoint** (RUN or STEP): `bp_en & pc_valid & pc_ret==bp_adr` pulses `quit_cmd`, sets `brk_hit`, and goes to HALTING.
- **HALTING**:
  - `cmd_ready`=0.
  - Count HALT_CYC cycles, then go to IDLE.
- **Calibration lost**: `init_calib_complete` falling in RUN or STEP goes straight to IDLE with no pulse. The status block already stalls the core.
- **Commands in other states**:
  - START or STEP while in RUN, STEP or WAIT_CAL is accepted and dropped.
  - QUIT in IDLE is dropped.
- **BRK_SET / BRK_CLR**: accepted in every state except HALTING. They write `bp_adr`/`bp_en` (set, or clear), effective from the next cycle.
- **Simultaneous events**: breakpoint, step-count expiry and QUIT in the same cycle produce exactly one `quit_cmd` pulse. `brk_hit` is set if the breakpoint matched; `step_done` pulses if the count expired.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `cpu_start`, `quit_cmd`, `step_done`, `running`, `brk_hit`, `bp_en` = 0
  - `cmd_ready` = 1
  - `start_adr` = RESET_ADR
  - step counter = 0
- Command accepted at cycle T → `cpu_start` high in T+1 only; `running` = 1 from T+1.
- `start_adr` is valid from T+1 and held stable until the next START.
- Breakpoint match or final `pc_valid` at T → `quit_cmd` in T+1; `running` = 0 from T+1.
- `cmd_ready` = 0 from T+1 through T+HALTING+HALT_CYC; first acceptance is possible HALT_CYC+1 cycles after the `quit_cmd` cycle.
- WAIT_CAL: calibration rising at T → `cpu_start` at T+1.
- Reset asserted mid-operation returns all outputs to reset values at the next edge; no `quit_cmd` is emitted.

## Structure
- Shared package: command code constants (CMD_START..CMD_BRK_CLR) and the state enum, both shared with the monitor command decoder.
- One sub-module, `run_step_counter`:
  - load with the 0→1 fix-up;
  - decrement on `pc_valid`;
  - `expire` output, combinational on count==1 & `pc_valid`.
- Breakpoint compare stays inline.

## Test plan
- **Calibrated start**: calib=1; START 0x0000_0100 at T → `cpu_start`=1 at T+1 only, `start_adr`=0x100, `running`=1.
- **Start before calibration**: calib=0; START; calib rises 20 cycles later at C → `cpu_start` at C+1 only; no pulse before.
- **Three-step**: STEP count=3 with `pc_valid` every other cycle → after the 3rd `pc_valid` at T: `quit_cmd` and `step_done` at T+1; `cmd_ready`=0 for 6 cycles.
- **Breakpoint stop**: BRK_SET 0x0000_0040, START, retire PCs 0x38, 0x3C, 0x40 → `quit_cmd` one cycle after 0x40; `brk_hit`=1 until the next START.
- **Coincident stop causes**: QUIT, breakpoint match and step expiry in the same cycle → exactly one `quit_cmd`, `brk_hit`=1, `step_done`=1.
- **Reset mid-run**: `rst_n`=1 during RUN → next edge: IDLE, `running`=0, `start_adr`=RESET_ADR, `quit_cmd`=0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control definitions: monitor command codes and FSM state encoding.
// Imported by the sequencer and by the monitor command decoder.
package cpu_run_ctrl_pkg;

  localparam logic [2:0] CMD_START   = 3'd1;
  localparam logic [2:0] CMD_QUIT    = 3'd2;
  localparam logic [2:0] CMD_STEP    = 3'd3;
  localparam logic [2:0] CMD_BRK_SET = 3'd4;
  localparam logic [2:0] CMD_BRK_CLR = 3'd5;

  typedef logic [2:0] run_state_t;

  localparam run_state_t ST_IDLE     = 3'd0;
  localparam run_state_t ST_WAIT_CAL = 3'd1;
  localparam run_state_t ST_RUN      = 3'd2;
  localparam run_state_t ST_STEP     = 3'd3;
  localparam run_state_t ST_HALTING  = 3'd4;

endpackage

// File: rtl/cpu_run_ctrl_step_counter.sv
// Single/multi-step instruction counter; a requested count of 0 runs one step.
// expire flags the retirement that finishes the sequence.
module run_step_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         pc_valid,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = (load_val == '0) ? W'(1) : load_val;
    else if (pc_valid && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  assign expire = pc_valid && (cnt_q == W'(1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns monitor commands into cpu_start/quit_cmd pulses,
// gates on DRAM calibration, and stops on breakpoint or step-count expiry.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int          HALT_CYC  = 5,
  parameter int          STEP_W    = 16,
  parameter logic [31:0] RESET_ADR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_code,
  input  logic [31:0] cmd_data,
  input  logic        init_calib_complete,
  input  logic        pc_valid,
  input  logic [31:0] pc_ret,
  output logic        cpu_start,
  output logic        quit_cmd,
  output logic [31:0] start_adr,
  output logic        running,
  output logic        brk_hit,
  output logic        step_done
);

  localparam int HW = (HALT_CYC < 2) ? 1 : $clog2(HALT_CYC + 1);

  run_state_t  state_q, state_d;
  logic [HW-1:0] halt_cnt_q, halt_cnt_d;
  logic [31:0] start_adr_q, start_adr_d;
  logic [31:0] bp_adr_q, bp_adr_d;
  logic        bp_en_q, bp_en_d;
  logic        brk_hit_q, brk_hit_d;
  logic        tgt_step_q, tgt_step_d;
  logic        cpu_start_q, cpu_start_d;
  logic        quit_q, quit_d;
  logic        step_done_q, step_done_d;
  logic        running_q, running_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic acc, is_start, is_quit, is_step, is_bset, is_bclr;
  logic bp_match, step_dec, expire, cnt_load;

  assign acc      = cmd_valid && cmd_ready_q;
  assign is_start = acc && cmd_code == CMD_START;
  assign is_quit  = acc && cmd_code == CMD_QUIT;
  assign is_step  = acc && cmd_code == CMD_STEP;
  assign is_bset  = acc && cmd_code == CMD_BRK_SET;
  assign is_bclr  = acc && cmd_code == CMD_BRK_CLR;

  assign bp_match = bp_en_q && pc_valid && pc_ret == bp_adr_q;
  assign step_dec = pc_valid && state_q == ST_STEP;

  run_step_counter #(.W(STEP_W)) u_step (
    .clk      (clk),
    .rst      (rst_n),
    .load     (cnt_load),
    .load_val (cmd_data[STEP_W-1:0]),
    .pc_valid (step_dec),
    .expire   (expire)
  );

  always_comb begin
    state_d     = state_q;
    halt_cnt_d  = halt_cnt_q;
    start_adr_d = start_adr_q;
    bp_adr_d    = bp_adr_q;
    bp_en_d     = bp_en_q;
    brk_hit_d   = brk_hit_q;
    tgt_step_d  = tgt_step_q;
    cpu_start_d = 1'b0;
    quit_d      = 1'b0;
    step_done_d = 1'b0;
    cnt_load    = 1'b0;

    if (is_bset) begin
      bp_adr_d = cmd_data;
      bp_en_d  = 1'b1;
    end
    if (is_bclr) bp_en_d = 1'b0;
    if (is_start || is_step) brk_hit_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_start) begin
          start_adr_d = cmd_data;
          tgt_step_d  = 1'b0;
          if (init_calib_complete) begin
            state_d     = ST_RUN;
            cpu_start_d = 1'b1;
          end else begin
            state_d = ST_WAIT_CAL;
          end
        end else if (is_step) begin
          cnt_load   = 1'b1;
          tgt_step_d = 1'b1;
          if (init_calib_complete) begin
            state_d     = ST_STEP;
            cpu_start_d = 1'b1;
          end else begin
            state_d = ST_WAIT_CAL;
          end
        end
      end
      ST_WAIT_CAL: begin
        if (is_quit) begin
          state_d = ST_IDLE;
        end else if (init_calib_complete) begin
          state_d     = tgt_step_q ? ST_STEP : ST_RUN;
          cpu_start_d = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        // Losing calibration aborts silently; the core is already stalled.
        if (!init_calib_complete) begin
          state_d = ST_IDLE;
        end else if (bp_match || is_quit || expire) begin
          state_d     = ST_HALTING;
          halt_cnt_d  = '0;
          quit_d      = 1'b1;
          step_done_d = expire;
          if (bp_match) brk_hit_d = 1'b1;
        end
      end
      ST_HALTING: begin
        if (halt_cnt_q == HW'(HALT_CYC)) state_d = ST_IDLE;
        else halt_cnt_d = halt_cnt_q + HW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    running_d   = state_d == ST_RUN || state_d == ST_STEP;
    cmd_ready_d = state_d != ST_HALTING;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      halt_cnt_q  <= '0;
      start_adr_q <= RESET_ADR;
      bp_adr_q    <= '0;
      bp_en_q     <= 1'b0;
      brk_hit_q   <= 1'b0;
      tgt_step_q  <= 1'b0;
      cpu_start_q <= 1'b0;
      quit_q      <= 1'b0;
      step_done_q <= 1'b0;
      running_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      halt_cnt_q  <= halt_cnt_d;
      start_adr_q <= start_adr_d;
      bp_adr_q    <= bp_adr_d;
      bp_en_q     <= bp_en_d;
      brk_hit_q   <= brk_hit_d;
      tgt_step_q  <= tgt_step_d;
      cpu_start_q <= cpu_start_d;
      quit_q      <= quit_d;
      step_done_q <= step_done_d;
      running_q   <= running_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cpu_start = cpu_start_q;
  assign quit_cmd  = quit_q;
  assign start_adr = start_adr_q;
  assign running   = running_q;
  assign brk_hit   = brk_hit_q;
  assign step_done = step_done_q;

endmodule
